// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES round-datapath types, constants and GF(2^8) helpers
//               (xtime, ShiftRows, single-column MixColumns).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int          AES_STATE_W = 128;
    localparam logic [7:0]  AES_POLY    = 8'h1B;

    typedef logic [AES_STATE_W-1:0] state_t;

    // Multiply by {02} in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Byte (r,c) lives at bit offset 127 - 8*(4c + r): column-major, s(0,0) in the MSB.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_mix_column.sv
// ============================================================================
// Module      : aes_mix_column
// Description : Combinational MixColumns for one 32-bit state column.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    assign o_col = mix_column(i_col);

endmodule

`default_nettype wire

// File: rtl/aes_shift_mix_stage.sv
// ============================================================================
// Module      : aes_shift_mix_stage
// Description : ShiftRows + MixColumns round stage (MixColumns bypassed on the
//               final round) in a 2-deep valid/ready pipeline with a saturating
//               completed-block counter. Optional macro ADD_ROUND_KEY_EN folds
//               the round-key XOR into the first pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_shift_mix_stage
    import aes_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_last,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [AES_STATE_W-1:0] in_rkey,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic [CNT_W-1:0]       blk_count
);

    state_t             w_shifted;
    state_t             w_mixed;
    state_t             w_round;
    state_t             w_s1_next;

    logic               w_s1_ready;
    logic               w_s2_ready;
    logic               w_in_fire;
    logic               w_out_fire;

    logic               r_s1_valid;
    state_t             r_s1_data;
    logic [TAG_W-1:0]   r_s1_tag;

    logic               r_s2_valid;
    state_t             r_s2_data;
    logic [TAG_W-1:0]   r_s2_tag;

    logic [CNT_W-1:0]   r_blk_count;

    // ------------------------------------------------------------------
    // S1 combinational datapath
    // ------------------------------------------------------------------
    assign w_shifted = shift_rows(in_data);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mix
            aes_mix_column u_mix_column (
                .i_col (w_shifted[AES_STATE_W-1-32*gi -: 32]),
                .o_col (w_mixed[AES_STATE_W-1-32*gi -: 32])
            );
        end
    endgenerate

    assign w_round = in_last ? w_shifted : w_mixed;

`ifdef ADD_ROUND_KEY_EN
    assign w_s1_next = w_round ^ in_rkey;
`else
    // Key addition happens downstream; the reduction only marks the port as intentionally unused.
    logic w_unused_rkey;
    assign w_unused_rkey = ^in_rkey;
    assign w_s1_next     = w_round;
`endif

    // ------------------------------------------------------------------
    // Handshake: a stage accepts when empty or when draining this cycle
    // ------------------------------------------------------------------
    assign w_s2_ready = !r_s2_valid || out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign in_ready   = !rst && w_s1_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_s1_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_data <= w_s1_next;
                r_s1_tag  <= in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_ready && r_s1_valid) begin
                r_s2_data <= r_s1_data;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // Saturating count of output handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (w_out_fire && (r_blk_count != {CNT_W{1'b1}})) begin
            r_blk_count <= r_blk_count + CNT_W'(1);
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_tag   = r_s2_tag;
    assign blk_count = r_blk_count;

endmodule

`default_nettype wire

// File: tb/tb_aes_shift_mix_stage.sv
// ============================================================================
// Module      : tb_aes_shift_mix_stage
// Description : Directed self-checking bench for aes_shift_mix_stage
//               (honours ADD_ROUND_KEY_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_shift_mix_stage;

    localparam int TAG_W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [3:0]   in_tag;
    logic [127:0] in_rkey;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
    logic [31:0]  blk_count;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [127:0] s_out_data;
    logic [3:0]   s_out_tag;
    logic [3:0]   s_blk_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_shift_mix_stage #(.TAG_W(TAG_W), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .in_rkey   (in_rkey),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .blk_count (blk_count)
    );

    aes_shift_mix_stage #(.TAG_W(TAG_W), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .in_rkey   (in_rkey),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .out_tag   (s_out_tag),
        .blk_count (s_blk_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One beat into an idle pipeline with out_ready held high; returns what was observed.
    task automatic run_single(input logic [127:0] d, input logic last, input logic [127:0] key,
                              input logic [3:0] tag, output logic v_early, output logic v_late,
                              output logic [127:0] od, output logic [3:0] ot);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_rkey   = key;
        in_tag    = tag;
        out_ready = 1'b1;
        tick;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_rkey   = '0;
        in_tag    = '0;
        v_early   = out_valid;
        tick;
        v_late    = out_valid;
        od        = out_data;
        ot        = out_tag;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_tag = '0; in_rkey = '0; out_ready = 1'b0;
        tick; tick;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_vec++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        n_vec++; if (blk_count !== 32'd0) begin n_err++; $display("FAIL reset_blk_count: got %0d expected 0", blk_count); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        tick;
    endtask

    task automatic test_fips_round;
        logic v1, v2; logic [127:0] od; logic [3:0] ot;
        run_single(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h0, 4'h5, v1, v2, od, ot);
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL round_latency_early: got %b expected 0", v1); end
        n_vec++; if (v2 !== 1'b1) begin n_err++; $display("FAIL round_latency_valid: got %b expected 1", v2); end
        n_vec++; if (od !== 128'h046681e5e0cb199a48f8d37a2806264c) begin n_err++; $display("FAIL round_data: got %h expected 046681e5e0cb199a48f8d37a2806264c", od); end
        n_vec++; if (ot !== 4'h5) begin n_err++; $display("FAIL round_tag: got %h expected 5", ot); end
        n_vec++; if (blk_count !== 32'd1) begin n_err++; $display("FAIL round_blk_count: got %0d expected 1", blk_count); end
    endtask

    task automatic test_last_round;
        logic v1, v2; logic [127:0] od; logic [3:0] ot;
        run_single(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'h0, 4'hA, v1, v2, od, ot);
        n_vec++; if (v2 !== 1'b1) begin n_err++; $display("FAIL last_valid: got %b expected 1", v2); end
        n_vec++; if (od !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin n_err++; $display("FAIL last_data: got %h expected d4bf5d30e0b452aeb84111f11e2798e5", od); end
        n_vec++; if (ot !== 4'hA) begin n_err++; $display("FAIL last_tag: got %h expected a", ot); end
    endtask

    task automatic test_rkey;
        logic v1, v2; logic [127:0] od; logic [3:0] ot; logic [127:0] exp;
`ifdef ADD_ROUND_KEY_EN
        exp = 128'ha49c7ff2689f352b6b5bea43026a5049;
`else
        exp = 128'h046681e5e0cb199a48f8d37a2806264c;
`endif
        run_single(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0,
                   128'ha0fafe1788542cb123a339392a6c7605, 4'h3, v1, v2, od, ot);
        n_vec++; if (od !== exp) begin n_err++; $display("FAIL rkey_data: got %h expected %h", od, exp); end
    endtask

    task automatic test_mix_vectors;
        logic [31:0] cin  [3];
        logic [31:0] cexp [3];
        logic v1, v2; logic [127:0] od; logic [3:0] ot;
        cin  = '{32'hdb135345, 32'hf20a225c, 32'hd4d4d4d5};
        cexp = '{32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6};
        for (int i = 0; i < 3; i++) begin
            run_single({4{cin[i]}}, 1'b0, 128'h0, 4'(i), v1, v2, od, ot);
            n_vec++;
            if (od !== {4{cexp[i]}}) begin
                n_err++; $display("FAIL mix_col_%0d: got %h expected %h", i, od, {4{cexp[i]}});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] d   [4];
        logic         l   [4];
        logic [127:0] exp [4];
        d   = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'hd42711aee0bf98f1b8b45de51e415230,
                {4{32'hdb135345}}, {4{32'hf20a225c}}};
        l   = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                {4{32'h8e4da1bc}}, {4{32'hf20a225c}}};
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 4);
            in_data  = (t < 4) ? d[t] : 128'h0;
            in_last  = (t < 4) ? l[t] : 1'b0;
            in_tag   = 4'(t + 8);
            if (t < 4) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_%0d: got %b expected 1", t, in_ready); end
            end
            if (t >= 2) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== exp[t-2] || out_tag !== 4'(t + 6)) begin
                    n_err++;
                    $display("FAIL b2b_beat_%0d: got v=%b %h tag %h expected v=1 %h tag %h",
                             t - 2, out_valid, out_data, out_tag, exp[t-2], 4'(t + 6));
                end
            end
            tick;
        end
        in_valid = 1'b0; in_last = 1'b0; in_tag = '0;
        tick;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        logic [127:0] exp [8];
        int  sent = 0, recv = 0, occ = 0, cyc = 0;
        logic hs_in, hs_out, exp_rdy;
        // Rows all equal and last=1 make the expected output identical to the input.
        for (int i = 0; i < 8; i++) exp[i] = {4{32'h0a1b2c3d + 32'h01010101 * 32'(i)}};
        while (recv < 8 && cyc < 300) begin
            out_ready = ($urandom_range(0, 2) == 0);
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? exp[sent] : 128'h0;
            in_last   = 1'b1;
            in_tag    = 4'(sent);
            #1;
            exp_rdy = !(occ == 2 && !out_ready);
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                n_vec++;
                if (out_data !== exp[recv] || out_tag !== 4'(recv)) begin
                    n_err++; $display("FAIL bp_beat_%0d: got %h tag %h expected %h tag %h",
                                      recv, out_data, out_tag, exp[recv], 4'(recv));
                end
                recv++;
            end
            if (hs_in) sent++;
            occ = occ + int'(hs_in) - int'(hs_out);
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++;
        if (recv != 8) begin n_err++; $display("FAIL bp_timeout: got %0d beats expected 8", recv); end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        tick; tick;
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; in_data = {4{32'h55aa33cc}}; in_tag = 4'h1;
        tick;
        in_data = {4{32'h66bb44dd}}; in_tag = 4'h2;
        tick;
        in_valid = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        rst = 1'b1;
        tick;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (blk_count !== 32'd0) begin n_err++; $display("FAIL midrst_blk_count: got %0d expected 0", blk_count); end
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale_%0d: got %b expected 0", i, out_valid); end
            tick;
        end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = {4{32'(i)}}; in_tag = 4'(i);
            tick;
        end
        in_valid = 1'b0;
        tick; tick; tick;
        n_vec++; if (blk_count !== 32'd20) begin n_err++; $display("FAIL sat_count32: got %0d expected 20", blk_count); end
        n_vec++; if (s_blk_count !== 4'd15) begin n_err++; $display("FAIL sat_count4: got %0d expected 15", s_blk_count); end
    endtask

    initial begin
        test_reset;
        test_fips_round;
        test_last_round;
        test_rkey;
        test_mix_vectors;
        test_back_to_back;
        test_backpressure;
        test_reset_midflight;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
